// File: rtl/sdram_arb_if.sv
// Requester-side and sdram_cnt-side signals of the sdram_arb arbiter.
// slave is the arbiter's view; master is the surrounding requesters and controller.
interface sdram_arb_if #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 12,
    parameter int DW        = 32
) ();
    logic [NUM_PORTS-1:0]    p_req;
    logic [NUM_PORTS-1:0]    p_we;
    logic [NUM_PORTS*AW-1:0] p_addr;
    logic [NUM_PORTS*DW-1:0] p_wdata;
    logic [NUM_PORTS-1:0]    p_ack;
    logic [NUM_PORTS-1:0]    p_rvalid;
    logic [DW-1:0]           p_rdata;
    logic [NUM_PORTS-1:0]    p_err;
    logic [NUM_PORTS-1:0]    gnt;
    logic                    en;
    logic                    we;
    logic [AW-1:0]           addr_in;
    logic [DW-1:0]           data_in;
    logic                    rdy;
    logic [DW-1:0]           data_out;
    logic                    valid;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, rdy, data_out, valid,
        output p_ack, p_rvalid, p_rdata, p_err, gnt, en, we, addr_in, data_in
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, rdy, data_out, valid,
        input  p_ack, p_rvalid, p_rdata, p_err, gnt, en, we, addr_in, data_in
    );
endinterface

// File: rtl/sdram_arb.sv
// Round-robin arbiter sharing one sdram_cnt user port among NUM_PORTS requesters.
// One transaction in flight; a stalled transaction is aborted with p_err after TIMEOUT cycles.
module sdram_arb #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    sdram_arb_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW:0]   NP   = (PW+1)'(NUM_PORTS);
    localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);
    localparam logic [15:0]   TLIM = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t               state, state_nx;
    logic [PW-1:0]        ptr, ptr_nx, own, own_nx, win;
    logic [PW:0]          scan;
    logic                 found, done;
    logic [15:0]          cnt, cnt_nx;
    logic                 en_nx, we_nx;
    logic [AW-1:0]        addr_nx;
    logic [DW-1:0]        data_nx, rdata_nx;
    logic [NUM_PORTS-1:0] gnt_nx, ack_nx, rv_nx, err_nx, own_oh;

    // first requester at or after ptr, wrapping modulo NUM_PORTS
    always_comb begin
        win   = ptr;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan = {1'b0, ptr} + (PW+1)'(i);
            if (scan >= NP) scan = scan - NP;
            if (!found && bus.p_req[scan[PW-1:0]]) begin
                win   = scan[PW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        own_oh      = '0;
        own_oh[own] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        own_nx   = own;
        cnt_nx   = cnt;
        en_nx    = 1'b0;
        we_nx    = bus.we;
        addr_nx  = bus.addr_in;
        data_nx  = bus.data_in;
        gnt_nx   = bus.gnt;
        ack_nx   = '0;
        rv_nx    = '0;
        err_nx   = '0;
        rdata_nx = bus.p_rdata;
        // writes finish on rdy after the controller went busy; reads on valid
        done     = bus.we ? (state == BUSY && bus.rdy) : bus.valid;
        unique case (state)
            IDLE: begin
                if (bus.rdy && found) begin
                    own_nx      = win;
                    gnt_nx      = '0;
                    gnt_nx[win] = 1'b1;
                    en_nx       = 1'b1;
                    we_nx       = bus.p_we[win];
                    addr_nx     = bus.p_addr[win*AW +: AW];
                    data_nx     = bus.p_wdata[win*DW +: DW];
                    ptr_nx      = (win == LAST) ? '0 : win + PW'(1);
                    cnt_nx      = '0;
                    state_nx    = ISSUE;
                end
            end
            ISSUE, BUSY: begin
                if (done) begin
                    ack_nx   = own_oh;
                    gnt_nx   = '0;
                    state_nx = IDLE;
                    if (!bus.we) begin
                        rv_nx    = own_oh;
                        rdata_nx = bus.data_out;
                    end
                end else if (cnt == TLIM) begin
                    err_nx   = own_oh;
                    gnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                    if (state == ISSUE && !bus.rdy) state_nx = BUSY;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            own          <= '0;
            cnt          <= '0;
            bus.en       <= 1'b0;
            bus.we       <= 1'b0;
            bus.addr_in  <= '0;
            bus.data_in  <= '0;
            bus.gnt      <= '0;
            bus.p_ack    <= '0;
            bus.p_rvalid <= '0;
            bus.p_err    <= '0;
            bus.p_rdata  <= '0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            own          <= own_nx;
            cnt          <= cnt_nx;
            bus.en       <= en_nx;
            bus.we       <= we_nx;
            bus.addr_in  <= addr_nx;
            bus.data_in  <= data_nx;
            bus.gnt      <= gnt_nx;
            bus.p_ack    <= ack_nx;
            bus.p_rvalid <= rv_nx;
            bus.p_err    <= err_nx;
            bus.p_rdata  <= rdata_nx;
        end
    end
endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: behavioural sdram_cnt model, per-port drivers,
// and a monitor popping expected responses computed from a flat memory model.
module tb_sdram_arb;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int LIM = 120;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_arb_if #(.NUM_PORTS(N), .AW(AW), .DW(DW)) bus ();

    sdram_arb #(.NUM_PORTS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap;
        bit            drop;
        bit            err;
    } tx_t;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
    } exp_t;

    tx_t           tx_q[N][$];
    exp_t          exp_q[N][$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] mem[logic [AW-1:0]];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            en_cyc = 0;
    int            en_cnt = 0;
    int            gnt_log[$];
    int            ack_log[$];
    bit            hang = 1'b0;

    logic          req_a[N];
    logic          we_a[N];
    logic [AW-1:0] addr_a[N];
    logic [DW-1:0] wd_a[N];

    always_comb begin
        bus.p_req   = '0;
        bus.p_we    = '0;
        bus.p_addr  = '0;
        bus.p_wdata = '0;
        for (int k = 0; k < N; k++) begin
            bus.p_req[k]            = req_a[k];
            bus.p_we[k]             = we_a[k];
            bus.p_addr[k*AW +: AW]  = addr_a[k];
            bus.p_wdata[k*DW +: DW] = wd_a[k];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit idle();
        for (int k = 0; k < N; k++)
            if (tx_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int p, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gap = 0,
                        input bit drop = 1'b0, input bit err = 1'b0);
        tx_t t;
        t.we = we; t.addr = a; t.data = d; t.gap = gap; t.drop = drop; t.err = err;
        tx_q[p].push_back(t);
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while (!idle()) begin
            @(negedge clk);
            i++;
            if (i > limit) begin
                n_chk++; n_err++;
                $display("FAIL wait_idle: still busy after %0d cycles, limit %0d", i, limit);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_en"}, bus.en, 0);
        chk({p, "_we"}, bus.we, 0);
        chk({p, "_gnt"}, bus.gnt, 0);
        chk({p, "_ack"}, bus.p_ack, 0);
        chk({p, "_rvalid"}, bus.p_rvalid, 0);
        chk({p, "_err"}, bus.p_err, 0);
        chk({p, "_addr"}, bus.addr_in, 0);
        chk({p, "_wdata"}, bus.data_in, 0);
        chk({p, "_rdata"}, bus.p_rdata, 0);
    endtask

    task automatic rst_on();
        @(negedge clk);
        rst_n = 1'b0;
        hang  = 1'b0;
    endtask

    task automatic rst_off();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // sdram_cnt stand-in: busy 1..6 cycles per command, optional rdy stall
    initial begin
        int            cnt;
        bit            stalled, pw, e, w, rd;
        logic [AW-1:0] pa, a;
        logic [DW-1:0] d;
        cnt = 0; stalled = 0; pw = 0; pa = '0;
        bus.rdy = 1'b1; bus.valid = 1'b0; bus.data_out = '0;
        forever begin
            @(negedge clk);
            e = bus.en; w = bus.we; a = bus.addr_in; d = bus.data_in; rd = bus.rdy;
            @(posedge clk);
            #1;
            bus.valid    = 1'b0;
            bus.data_out = $urandom;
            if (!rst_n) begin
                cnt = 0; stalled = 0; bus.rdy = 1'b1;
                continue;
            end
            if (stalled && !hang) begin
                stalled = 0;
                bus.rdy = 1'b1;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (hang) stalled = 1;
                    else begin
                        bus.rdy = 1'b1;
                        if (!pw) begin
                            bus.valid    = 1'b1;
                            bus.data_out = mem.exists(pa) ? mem[pa] : '0;
                        end
                    end
                end
            end
            if (e && rd) begin
                pw = w; pa = a;
                if (w) mem[a] = d;
                cnt = $urandom_range(6, 1);
                bus.rdy = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : drv
        initial begin
            tx_t  t;
            exp_t ex;
            int   gap, wt;
            bit   act;
            act = 0; gap = 0; wt = 0;
            t = '{default: '0};
            req_a[g] = 1'b0; we_a[g] = 1'b0; addr_a[g] = '0; wd_a[g] = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!rst_n) begin
                    act = 0; gap = 0; req_a[g] = 1'b0;
                    continue;
                end
                if (act) begin
                    if (bus.p_ack[g] || bus.p_err[g]) act = 0;
                    else begin
                        if (t.drop && bus.gnt[g]) req_a[g] = 1'b0;
                        wt++;
                        if (wt > LIM) begin
                            n_chk++; n_err++;
                            $display("FAIL drv_timeout port %0d: waited %0d cycles, limit %0d", g, wt, LIM);
                            act = 0; req_a[g] = 1'b0;
                        end
                    end
                end
                if (!act) begin
                    if (gap > 0) begin
                        gap--;
                        req_a[g] = 1'b0;
                    end else if (tx_q[g].size() != 0) begin
                        t = tx_q[g].pop_front();
                        req_a[g] = 1'b1; we_a[g] = t.we; addr_a[g] = t.addr; wd_a[g] = t.data;
                        ex.data = '0;
                        if (t.err) ex.kind = 2;
                        else if (t.we) begin
                            ref_mem[t.addr] = t.data;
                            ex.kind = 0;
                        end else begin
                            ex.kind = 1;
                            ex.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : '0;
                        end
                        exp_q[g].push_back(ex);
                        act = 1; wt = 0; gap = t.gap;
                    end else req_a[g] = 1'b0;
                end
            end
        end
    end

    // monitor: pops the scoreboard on every response pulse
    initial begin
        bit            prev_en;
        logic [DW-1:0] last_rd;
        exp_t          e;
        prev_en = 0; last_rd = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int k = 0; k < N; k++) exp_q[k].delete();
                prev_en = 0; last_rd = '0;
                continue;
            end
            if (prev_en) chk("en_width", bus.en, 0);
            if (bus.en) begin
                en_cnt++;
                en_cyc = cyc;
                chk("gnt_onehot", $countones(bus.gnt), 1);
                gnt_log.push_back(oh2i(bus.gnt));
            end
            prev_en = bus.en;
            for (int k = 0; k < N; k++) begin
                if (bus.p_ack[k] || bus.p_err[k] || bus.p_rvalid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_chk++; n_err++;
                        $display("FAIL unexpected_resp port %0d: ack=%b err=%b rvalid=%b, none outstanding",
                                 k, bus.p_ack[k], bus.p_err[k], bus.p_rvalid[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        ack_log.push_back(k);
                        chk("resp_gnt_clear", bus.gnt, 0);
                        if (e.kind == 2) begin
                            chk("err_pulse", bus.p_err[k], 1);
                            chk("err_no_ack", bus.p_ack[k], 0);
                            chk("err_latency", cyc - en_cyc, TO);
                        end else begin
                            chk("ack", bus.p_ack[k], 1);
                            chk("no_err", bus.p_err[k], 0);
                            chk("rvalid", bus.p_rvalid[k], e.kind == 1);
                            if (e.kind == 1) begin
                                chk("rdata", bus.p_rdata, e.data);
                                last_rd = e.data;
                            end else chk("rdata_hold", bus.p_rdata, last_rd);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int            e0, w;
        logic [AW-1:0] a1, a2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        repeat (17) @(negedge clk);
        rst_n = 1'b1;

        // single port write then read
        gnt_log.delete();
        push(0, 1, 12'h123, 32'hDEADBEEF);
        push(0, 0, 12'h123, '0);
        wait_idle(200);
        chk("t1_en_count", gnt_log.size(), 2);
        foreach (gnt_log[i]) chk("t1_gnt_port0", gnt_log[i], 0);

        // simultaneous requests straight after reset
        rst_on();
        gnt_log.delete(); ack_log.delete();
        push(0, 1, 12'h010, 32'h11111111);
        push(1, 1, 12'h020, 32'h22222222);
        push(0, 0, 12'h010, '0);
        push(1, 0, 12'h020, '0);
        rst_off();
        wait_idle(300);
        chk("t2_ack_count", ack_log.size(), 4);
        foreach (ack_log[i]) chk("t2_ack_order", ack_log[i], i % 2);

        // timeout with rdy held low after en
        hang = 1'b1;
        ack_log.delete();
        push(2, 0, 12'h2AA, '0, 0, 0, 1);
        wait_idle(100);
        chk("t4_err_port", ack_log.size() == 1 ? ack_log[0] : -1, 2);
        e0 = en_cnt;
        push(1, 1, 12'h155, 32'hCAFEF00D);
        repeat (8) @(negedge clk);
        chk("t4_no_issue_while_stalled", en_cnt, e0);
        hang = 1'b0;
        wait_idle(100);
        chk("t4_issue_after_rdy", en_cnt, e0 + 1);

        // reset while a read is in flight
        hang = 1'b1;
        e0 = en_cnt;
        push(3, 0, 12'h3AA, '0);
        w = 0;
        while (en_cnt == e0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t5_read_issued", en_cnt, e0 + 1);
        repeat (5) @(negedge clk);
        chk("t5_busy_gnt", bus.gnt, 4'b1000);
        rst_on();
        @(posedge clk);
        #1;
        check_zero("t5_mid_reset");

        // fairness: all four ports hold requests continuously
        gnt_log.delete();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 8; i++) begin
                a1 = {2'(k), 10'($urandom_range(1023, 0))};
                push(k, 1, a1, $urandom);
                push(k, 0, a1, '0);
            end
        rst_off();
        wait_idle(3000);
        chk("t3_grant_count", gnt_log.size(), 64);
        foreach (gnt_log[i]) chk("t3_grant_order", gnt_log[i], i % N);

        // soak with random gaps and early p_req drops
        for (int s = 0; s < 64; s++)
            for (int k = 0; k < N; k++) begin
                a1 = {2'(k), 10'($urandom_range(1023, 0))};
                a2 = {2'(k), 10'($urandom_range(1023, 0))};
                push(k, 1, a1, $urandom, $urandom_range(9, 0), 1'($urandom_range(3, 0) == 0));
                push(k, 1, a2, $urandom, $urandom_range(9, 0), 1'($urandom_range(3, 0) == 0));
                push(k, 0, a1, '0, $urandom_range(9, 0), 1'($urandom_range(3, 0) == 0));
                push(k, 0, a2, '0, $urandom_range(9, 0), 1'($urandom_range(3, 0) == 0));
            end
        wait_idle(60000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
